// File: rtl/key_debounce.sv
// key_debounce: synchronizes and debounces a push-button, then emits press/release strobes and auto-repeat strobes.
module key_debounce #(
  parameter int DB_CYCLES    = 100000,
  parameter int REPEAT_DELAY = 50000000,
  parameter int REPEAT_RATE  = 10000000,
  parameter int CNT_W        = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  input  logic repeat_en,
  output logic btn_level,
  output logic btn_pulse,
  output logic btn_release,
  output logic btn_repeat
);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
  state_t state, state_nx;
  logic s1, s2;
  logic [CNT_W-1:0] db_cnt, db_nx, rpt_cnt, rpt_nx;
  logic rate, rate_nx, rpt_fire, active;
  always_comb begin
    state_nx = state;
    db_nx    = '0;
    case (state)
      IDLE: begin
        state_nx = s2 ? PRESS_WAIT : IDLE;
        db_nx    = s2 ? ONE : '0;
      end
      PRESS_WAIT: begin
        state_nx = !s2 ? IDLE : (db_cnt == DB_LAST) ? HELD : PRESS_WAIT;
        db_nx    = (s2 && db_cnt != DB_LAST) ? db_cnt + ONE : '0;
      end
      HELD: begin
        state_nx = s2 ? HELD : RELEASE_WAIT;
        db_nx    = s2 ? '0 : ONE;
      end
      RELEASE_WAIT: begin
        state_nx = s2 ? HELD : (db_cnt == DB_LAST) ? IDLE : RELEASE_WAIT;
        db_nx    = (!s2 && db_cnt != DB_LAST) ? db_cnt + ONE : '0;
      end
      default: state_nx = IDLE;
    endcase
  end
  // repeat timing freezes across a release glitch instead of restarting
  always_comb begin
    active   = (state == HELD) || (state == RELEASE_WAIT);
    rpt_fire = (state == HELD) && repeat_en && (rpt_cnt == (rate ? RATE_LAST : DELAY_LAST));
    rpt_nx   = (!repeat_en || !active || rpt_fire) ? '0 :
               (state == RELEASE_WAIT) ? rpt_cnt : rpt_cnt + ONE;
    rate_nx  = (!repeat_en || !active) ? 1'b0 : (rate || rpt_fire);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      state       <= IDLE;
      db_cnt      <= '0;
      rpt_cnt     <= '0;
      rate        <= 1'b0;
      btn_level   <= 1'b0;
      btn_pulse   <= 1'b0;
      btn_release <= 1'b0;
      btn_repeat  <= 1'b0;
    end else begin
      s1          <= btn_in;
      s2          <= s1;
      state       <= state_nx;
      db_cnt      <= db_nx;
      rpt_cnt     <= rpt_nx;
      rate        <= rate_nx;
      btn_level   <= (state_nx == HELD) || (state_nx == RELEASE_WAIT);
      btn_pulse   <= (state == PRESS_WAIT) && (state_nx == HELD);
      btn_release <= (state == RELEASE_WAIT) && (state_nx == IDLE);
      btn_repeat  <= rpt_fire;
    end
  end
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed vector table plus reset corner sequences for key_debounce (DB=4, DELAY=10, RATE=3).
module tb_key_debounce;
  logic clk = 1'b0;
  logic reset, btn_in, repeat_en;
  logic btn_level, btn_pulse, btn_release, btn_repeat;
  logic [3:0] outs;
  int passed = 0;
  int total = 0;
  typedef struct {
    logic       btn;
    logic       ren;
    logic [3:0] exp;
  } vec_t;
  vec_t tv[$];
  always #5 clk = ~clk;
  assign outs = {btn_level, btn_pulse, btn_release, btn_repeat};
  key_debounce #(.DB_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_RATE(3), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in), .repeat_en(repeat_en),
    .btn_level(btn_level), .btn_pulse(btn_pulse), .btn_release(btn_release), .btn_repeat(btn_repeat)
  );
  function automatic void add(int n, logic b, logic r, logic [3:0] e);
    for (int i = 0; i < n; i++) tv.push_back('{b, r, e});
  endfunction
  task automatic check(string name, logic [3:0] got, logic [3:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got lvl/pul/rel/rpt=%b want %b", name, got, exp);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    // clean press, release
    add(5, 1, 0, 4'b0000); add(1, 1, 0, 4'b1100); add(1, 1, 0, 4'b1000);
    add(5, 0, 0, 4'b1000); add(1, 0, 0, 4'b0010); add(1, 0, 0, 4'b0000);
    // bounce 1,0,1,1,0 then low
    add(1, 1, 0, 4'b0000); add(1, 0, 0, 4'b0000); add(2, 1, 0, 4'b0000); add(4, 0, 0, 4'b0000);
    // held with auto-repeat: first at +10, then every 3
    add(5, 1, 1, 4'b0000); add(1, 1, 1, 4'b1100); add(9, 1, 1, 4'b1000); add(1, 1, 1, 4'b1001);
    add(2, 1, 1, 4'b1000); add(1, 1, 1, 4'b1001); add(2, 1, 1, 4'b1000); add(1, 1, 1, 4'b1001);
    // repeat disabled, then re-enabled restarts from the delay phase
    add(15, 1, 0, 4'b1000); add(9, 1, 1, 4'b1000); add(1, 1, 1, 4'b1001);
    add(2, 1, 1, 4'b1000); add(1, 1, 1, 4'b1001);
    // release while repeating
    add(2, 0, 1, 4'b1000); add(1, 0, 1, 4'b1001); add(2, 0, 1, 4'b1000);
    add(1, 0, 1, 4'b0010); add(1, 0, 1, 4'b0000);
    // press, 2-cycle release glitch freezes repeat count for 2 cycles
    add(5, 1, 1, 4'b0000); add(1, 1, 1, 4'b1100); add(5, 1, 1, 4'b1000); add(2, 0, 1, 4'b1000);
    add(4, 1, 1, 4'b1000); add(1, 1, 1, 4'b1001); add(2, 1, 1, 4'b1000); add(1, 1, 1, 4'b1001);
    add(5, 0, 0, 4'b1000); add(1, 0, 0, 4'b0010); add(1, 0, 0, 4'b0000);
    // DB_CYCLES-1 high samples is not enough
    add(3, 1, 0, 4'b0000); add(3, 0, 0, 4'b0000);
    reset = 1'b1; btn_in = 1'b0; repeat_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset", outs, 4'b0000);
    reset = 1'b0;
    for (int i = 0; i < tv.size(); i++) begin
      btn_in = tv[i].btn;
      repeat_en = tv[i].ren;
      @(negedge clk);
      check($sformatf("vec%0d", i), outs, tv[i].exp);
    end
    // reset while HELD with button still down: one fresh pulse DB+2 cycles later
    btn_in = 1'b1; repeat_en = 1'b1;
    for (int k = 0; k < 20 && !btn_level; k++) @(negedge clk);
    check("held_reach", outs, 4'b1100);
    reset = 1'b1;
    @(negedge clk);
    check("rst_in_held", outs, 4'b0000);
    reset = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      check($sformatf("rehold%0d", j), outs, j == 6 ? 4'b1100 : j == 7 ? 4'b1000 : 4'b0000);
    end
    // reset during RELEASE_WAIT: no release strobe afterwards
    btn_in = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rw_enter", outs, 4'b1000);
    end
    reset = 1'b1;
    @(negedge clk);
    check("rst_in_rw", outs, 4'b0000);
    reset = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      check($sformatf("post_rw%0d", j), outs, 4'b0000);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
